// File: rtl/pixel_feeder.sv
// Frame-buffered pixel feeder: loads a 64-pixel 8x8 frame from the host,
// then serves zero-padded 3-pixel window rows to the image controller on request.
module pixel_feeder #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic            en,
  input  logic            busy,
  input  logic [3:0]      x,
  input  logic [3:0]      y,
  input  logic [1:0]      stage,
  input  logic            valid,
  output logic [3*DW-1:0] pix_out,
  output logic            pix_valid
);

  typedef enum logic [1:0] {LOAD, START, SERVE} state_t;

  state_t          state;
  logic [5:0]      cnt;
  logic [DW-1:0]   mem [64];
  logic [4:0]      row_p0;
  logic [3*DW-1:0] win_p0;

  function automatic logic in_range(input logic [4:0] v);
    return (v >= 5'd1) && (v <= 5'd8);
  endfunction

  // Coordinates outside 1..8 (including 0 and 9) read as zero padding.
  function automatic logic [DW-1:0] rd_pix(input logic [4:0] r, input logic [4:0] c);
    logic [4:0] rm1;
    logic [4:0] cm1;
    rm1 = r - 5'd1;
    cm1 = c - 5'd1;
    if (in_range(r) && in_range(c))
      return mem[{rm1[2:0], cm1[2:0]}];
    return '0;
  endfunction

  assign in_ready = (state == LOAD);
  assign en       = (state == START);

  // Stage p0: window row address decode and buffer read
  always_comb begin
    row_p0 = {1'b0, x} + {3'b000, stage} - 5'd1;
    win_p0 = {rd_pix(row_p0, {1'b0, y} - 5'd1),
              rd_pix(row_p0, {1'b0, y}),
              rd_pix(row_p0, {1'b0, y} + 5'd1)};
  end

  // Frame buffer deliberately has no reset so contents persist across frames.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid)
      mem[cnt] <= in_data;
  end

  // Stage p1: control FSM and registered window output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      pix_valid <= 1'b0;
      pix_out   <= '0;
    end else begin
      case (state)
        LOAD: begin
          pix_valid <= 1'b0;
          if (in_valid) begin
            if (cnt == 6'd63) begin
              state <= START;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        START: begin
          pix_valid <= 1'b0;
          state     <= SERVE;
        end
        SERVE: begin
          if (valid) begin
            state     <= LOAD;
            cnt       <= '0;
            pix_valid <= 1'b0;
          end else if (busy && stage != 2'd3) begin
            pix_out   <= win_p0;
            pix_valid <= 1'b1;
          end else begin
            pix_valid <= 1'b0;
          end
        end
        default: begin
          state     <= LOAD;
          pix_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_feeder.sv
// Scoreboard bench for pixel_feeder: loads frames, requests window rows and
// compares each valid output against a bench-side frame model.
module tb_pixel_feeder;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic            en;
  logic            busy;
  logic [3:0]      x;
  logic [3:0]      y;
  logic [1:0]      stage;
  logic            valid;
  logic [3*DW-1:0] pix_out;
  logic            pix_valid;

  int              checks = 0;
  int              errors = 0;
  logic [DW-1:0]   ref_mem [64];
  logic [3*DW-1:0] sb [$];
  logic [3*DW-1:0] last_exp;

  pixel_feeder #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .en(en), .busy(busy), .x(x), .y(y),
    .stage(stage), .valid(valid), .pix_out(pix_out), .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3*DW-1:0] model(input int xx, input int yy, input int ss);
    logic [3*DW-1:0] res;
    int r;
    int c;
    res = '0;
    r = xx - 1 + ss;
    for (int k = 0; k < 3; k++) begin
      c = yy - 1 + k;
      res = res << DW;
      if (r >= 1 && r <= 8 && c >= 1 && c <= 8)
        res[DW-1:0] = ref_mem[(r - 1) * 8 + (c - 1)];
    end
    return res;
  endfunction

  function automatic logic [DW-1:0] pixval(input int kind, input int i);
    case (kind)
      0:       return DW'(i + 1);
      1:       return DW'(200);
      default: return DW'(255 - i);
    endcase
  endfunction

  // Every cycle that reports a valid row must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && pix_valid) begin
      if (sb.size() == 0)
        chk("sb_unexpected", 64'(pix_valid), 64'd0);
      else
        chk("pix_out", 64'(pix_out), 64'(sb.pop_front()));
    end
  end

  task automatic load_frame(input int kind, input bit gap, input bit vstart);
    for (int i = 0; i < 64; i++) begin
      if (gap) begin
        in_valid = 1'b0;
        tick();
        chk("gap_ready", 64'(in_ready), 64'd1);
        chk("gap_en", 64'(en), 64'd0);
      end
      in_valid = 1'b1;
      in_data  = pixval(kind, i);
      ref_mem[i] = in_data;
      chk("ld_ready", 64'(in_ready), 64'd1);
      chk("ld_en", 64'(en), 64'd0);
      tick();
    end
    // Extra host write and controller completion during START must both be ignored.
    in_valid = 1'b1;
    in_data  = 8'hEE;
    valid    = vstart;
    chk("start_en", 64'(en), 64'd1);
    chk("start_ready", 64'(in_ready), 64'd0);
    tick();
    valid = 1'b0;
    chk("serve_en", 64'(en), 64'd0);
    chk("serve_ready", 64'(in_ready), 64'd0);
  endtask

  task automatic req(input int xx, input int yy, input int ss, input bit b);
    logic exp_v;
    x     = 4'(xx);
    y     = 4'(yy);
    stage = 2'(ss);
    busy  = b;
    exp_v = b && (ss != 3);
    if (exp_v) begin
      last_exp = model(xx, yy, ss);
      sb.push_back(last_exp);
    end
    tick();
    busy = 1'b0;
    chk("pix_valid", 64'(pix_valid), 64'(exp_v));
    if (!exp_v)
      chk("pix_hold", 64'(pix_out), 64'(last_exp));
  endtask

  task automatic pulse_valid();
    in_valid = 1'b0;
    valid    = 1'b1;
    tick();
    valid = 1'b0;
    chk("vp_ready", 64'(in_ready), 64'd1);
    chk("vp_pix_valid", 64'(pix_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; busy = 1'b0;
    x = 4'd1; y = 4'd1; stage = 2'd0; valid = 1'b0;
    last_exp = '0;
    #1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_en", 64'(en), 64'd0);
    chk("rst_pix_valid", 64'(pix_valid), 64'd0);
    chk("rst_pix_out", 64'(pix_out), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Frame 1: back-to-back load, corner windows, in_valid held high while serving
    load_frame(0, 1'b0, 1'b0);
    req(1, 1, 0, 1'b1);
    req(1, 1, 1, 1'b1);
    req(1, 1, 2, 1'b1);
    chk("c11_s2", 64'(last_exp), 64'h00090A);
    req(8, 8, 0, 1'b1);
    chk("c88_s0", 64'(last_exp), 64'h373800);
    req(8, 8, 1, 1'b1);
    req(8, 8, 2, 1'b1);
    req(8, 8, 3, 1'b1);
    req(3, 5, 1, 1'b1);
    req(3, 5, 1, 1'b0);
    pulse_valid();

    // Frame 2: gapped load with valid asserted during START
    load_frame(0, 1'b1, 1'b1);
    req(1, 1, 1, 1'b1);
    chk("c11_s1", 64'(last_exp), 64'h000102);
    req(6, 4, 2, 1'b1);
    pulse_valid();

    // Frame 3: flat value
    load_frame(1, 1'b0, 1'b0);
    req(4, 4, 1, 1'b1);
    chk("flat", 64'(last_exp), 64'hC8C8C8);
    req(1, 8, 0, 1'b1);
    pulse_valid();

    // Reset mid-load abandons the partial frame
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h55;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_en", 64'(en), 64'd0);
    chk("mid_rst_pix_valid", 64'(pix_valid), 64'd0);
    chk("mid_rst_pix_out", 64'(pix_out), 64'd0);
    last_exp = '0;
    tick();
    rst = 1'b0;
    tick();
    load_frame(2, 1'b0, 1'b0);
    req(5, 2, 2, 1'b1);
    chk("desc", 64'(last_exp), 64'hD7D6D5);
    req(8, 1, 1, 1'b1);
    req(2, 2, 0, 1'b0);

    tick(); tick();
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
